// File: rtl/filter_pad_pkg.sv
// Shared constants for the filter scratchpad, the filter loader and the PE.
// Holds the default filter geometry and a width helper for derived address widths.
package filter_pad_pkg;

  localparam int unsigned DEF_FILTER_WIDTH = 16;
  localparam int unsigned DEF_FILTER_ROW   = 12;
  localparam int unsigned DEF_FILTER_SLOTS = 4;

  // $clog2 that never returns 0, so a single-entry dimension still gets a 1-bit index
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int unsigned DEF_ROW_W  = clog2_min1(DEF_FILTER_ROW);
  localparam int unsigned DEF_SLOT_W = clog2_min1(DEF_FILTER_SLOTS);
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_FILTER_SLOTS + 1);

endpackage

// File: rtl/filter_pad_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// No reset so it maps onto block or distributed RAM. rdata_o updates only when re_i.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read enable and address
//   rdata_o          registered read data
module filter_pad_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 48,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/filter_slot_buffer.sv
// Multi-slot filter scratchpad. Filters stream in over valid/ready and fill a ring of
// slots; a slot commits when its last row is written. The PE reads the oldest committed
// slot by row (1-cycle registered read) and then releases it.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   chip_en_i              0 holds all state
//   flush_i                drops all slots and any partial fill (memory kept)
//   din_i/din_valid_i/din_ready_o   write stream
//   ren_i/raddr_i          read request on head slot
//   dout_o/dout_valid_o    registered read data and its valid
//   rd_err_o               pulse for a rejected read
//   release_slot_i         free head slot
//   slot_count_o, full_o, empty_o   occupancy
module filter_slot_buffer
  import filter_pad_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int unsigned FILTER_ROW   = DEF_FILTER_ROW,
  parameter int unsigned FILTER_SLOTS = DEF_FILTER_SLOTS,
  localparam int unsigned ROW_W  = clog2_min1(FILTER_ROW),
  localparam int unsigned SLOT_W = clog2_min1(FILTER_SLOTS),
  localparam int unsigned CNT_W  = $clog2(FILTER_SLOTS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    chip_en_i,
  input  logic                    flush_i,
  input  logic [FILTER_WIDTH-1:0] din_i,
  input  logic                    din_valid_i,
  output logic                    din_ready_o,
  input  logic                    ren_i,
  input  logic [ROW_W-1:0]        raddr_i,
  output logic [FILTER_WIDTH-1:0] dout_o,
  output logic                    dout_valid_o,
  output logic                    rd_err_o,
  input  logic                    release_slot_i,
  output logic [CNT_W-1:0]        slot_count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned DEPTH  = FILTER_SLOTS * FILTER_ROW;
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);

  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d;
  logic [CNT_W-1:0]  slot_count_q, slot_count_d;
  logic              dout_valid_q, dout_valid_d;
  logic              rd_err_q, rd_err_d;
  // Forces dout to 0 after reset or a rejected read without touching RAM data
  logic              dout_zero_q, dout_zero_d;

  logic              full, empty;
  logic              wr_fire, wr_last, commit;
  logic              rd_req, rd_ok, rel;
  logic [ADDR_W-1:0] waddr, raddr_full;
  logic [FILTER_WIDTH-1:0] ram_rdata;

  always_comb begin
    full        = (slot_count_q == CNT_W'(FILTER_SLOTS));
    empty       = (slot_count_q == '0);
    din_ready_o = chip_en_i & ~full & ~flush_i;
    wr_fire     = din_valid_i & din_ready_o;
    wr_last     = (wr_row_q == ROW_W'(FILTER_ROW - 1));
    commit      = wr_fire & wr_last;
    rd_req      = chip_en_i & ren_i & ~flush_i;
    rd_ok       = rd_req & ~empty & (32'(raddr_i) < FILTER_ROW);
    rel         = chip_en_i & release_slot_i & ~empty & ~flush_i;
    waddr       = ADDR_W'(wr_slot_q) * ADDR_W'(FILTER_ROW) + ADDR_W'(wr_row_q);
    raddr_full  = ADDR_W'(rd_slot_q) * ADDR_W'(FILTER_ROW) + ADDR_W'(raddr_i);
  end

  always_comb begin
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    wr_row_d     = wr_row_q;
    slot_count_d = slot_count_q;
    dout_valid_d = dout_valid_q;
    rd_err_d     = rd_err_q;
    dout_zero_d  = dout_zero_q;

    if (flush_i) begin
      wr_slot_d    = '0;
      rd_slot_d    = '0;
      wr_row_d     = '0;
      slot_count_d = '0;
      dout_valid_d = 1'b0;
      rd_err_d     = 1'b0;
    end else if (chip_en_i) begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_row_d  = '0;
          wr_slot_d = (wr_slot_q == SLOT_W'(FILTER_SLOTS - 1)) ? '0 : wr_slot_q + SLOT_W'(1);
        end else begin
          wr_row_d = wr_row_q + ROW_W'(1);
        end
      end

      if (rel) begin
        rd_slot_d = (rd_slot_q == SLOT_W'(FILTER_SLOTS - 1)) ? '0 : rd_slot_q + SLOT_W'(1);
      end

      unique case ({commit, rel})
        2'b10:   slot_count_d = slot_count_q + CNT_W'(1);
        2'b01:   slot_count_d = slot_count_q - CNT_W'(1);
        default: slot_count_d = slot_count_q;
      endcase

      dout_valid_d = rd_ok;
      rd_err_d     = rd_req & ~rd_ok;
      if (rd_ok) begin
        dout_zero_d = 1'b0;
      end else if (rd_req) begin
        dout_zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_slot_q    <= '0;
      rd_slot_q    <= '0;
      wr_row_q     <= '0;
      slot_count_q <= '0;
      dout_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
      dout_zero_q  <= 1'b1;
    end else begin
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      wr_row_q     <= wr_row_d;
      slot_count_q <= slot_count_d;
      dout_valid_q <= dout_valid_d;
      rd_err_q     <= rd_err_d;
      dout_zero_q  <= dout_zero_d;
    end
  end

  filter_pad_ram #(
    .Width (FILTER_WIDTH),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_fire & ~rst_i),
    .waddr_i (waddr),
    .wdata_i (din_i),
    .re_i    (rd_ok & ~rst_i),
    .raddr_i (raddr_full),
    .rdata_o (ram_rdata)
  );

  assign dout_o       = dout_zero_q ? '0 : ram_rdata;
  assign dout_valid_o = dout_valid_q;
  assign rd_err_o     = rd_err_q;
  assign slot_count_o = slot_count_q;
  assign full_o       = full;
  assign empty_o      = empty;

endmodule
